fp_accumulator: RTL
===================

# fp_accumulator

- Single-precision floating-point accumulator placed directly downstream of the `multiple` multiplier.
- Consumes each product on the `mul_done` strobe and adds it into a running sum. Aligns, adds and normalizes in a fixed 3-cycle pipeline.
- Reports the sum, the count of accumulated products, and sticky overflow/drop status.
- Used to build dot products out of successive multiplies.

## Interface
- `COUNT_W`, default 8: width of the accumulated-product counter.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `acc_clear` in 1: synchronous clear of sum, count and status.
- `prod_valid` in 1: product strobe; connect to multiplier `mul_done`.
- `prod_overflow` in 1: connect to multiplier `mul_overflow`.
- `prod` in 32: IEEE-754 single product; connect to `mul_result`.
- `acc_busy` out 1: high whenever the state is not IDLE.
- `acc_done` out 1: one-cycle pulse when `acc_result` updates.
- `acc_result` out 32: running sum.
- `acc_count` out COUNT_W: number of products accumulated.
- `acc_overflow` out 1: sticky overflow.
- `acc_drop` out 1: sticky flag; a product arrived while busy.

## Operation
- **States:** IDLE -> ALIGN -> ADD -> NORM -> IDLE.
- **Reset:** all outputs 0 and state IDLE, including `acc_result` = 0x00000000.
- **Accept:** in IDLE with `prod_valid`=1 and `acc_clear`=0, `prod` is captured and the state goes to ALIGN.
- **Overflow or special input:** if `prod_overflow`=1 or `prod` has exponent 255:
  - `acc_overflow` is set.
  - No add is performed and the sum is unchanged.
  - `acc_done` still pulses and `acc_count` still increments.
- **Zero/denormal inputs:** exponent 0 in either operand is treated as +0 (flush).
- **ALIGN:**
  - The larger-magnitude operand (compare exponent, then mantissa) is kept.
  - The other operand's 24-bit mantissa, hidden bit included, is shifted right by the exponent difference. Shifted-out bits are discarded (truncation).
  - An exponent difference of 25 or more makes that mantissa 0.
- **ADD:**
  - Same signs: add the mantissas into a 25-bit result.
  - Opposite signs: larger minus smaller.
  - Result sign is the sign of the larger operand.
  - An exact cancellation gives +0.
- **NORM:**
  - Carry out: shift right 1 (truncate) and exponent +1.
  - Otherwise: shift left by the leading-zero count (single-cycle priority encoder) and exponent minus that count.
  - Exponent <= 0 after normalization: result is +0.
  - Exponent >= 255: result is sign|0x7F800000 and `acc_overflow` is set.
- **Count:** `acc_count` increments on each `acc_done` and saturates at all-ones.
- **Drop:** `prod_valid`=1 while not IDLE sets `acc_drop`; the product is ignored.
- **`acc_clear`:**
  - Zeroes `acc_result`, `acc_count`, `acc_overflow` and `acc_drop`.
  - Wins over a simultaneous `prod_valid`; that product is discarded and `acc_drop` is not set.
  - Asserted while busy, it aborts the in-flight add: state goes to IDLE and no `acc_done` pulse is produced.
- **Reset mid-operation:** same as reset, no `acc_done`.

## Timing
- **Accept edge E:** `acc_busy`=1 after E.
- **Pipeline:** ALIGN is active in cycle E..E+1, ADD E+1..E+2, NORM E+2..E+3.
- **Completion edge E+3:**
  - `acc_result`, `acc_count` and status flags update.
  - `acc_done`=1 for exactly one cycle.
  - `acc_busy`=0.
- **Latency:** 3 cycles from accept to result.
- **Throughput:** earliest next accept at edge E+4, i.e. one product per 4 cycles.
- **Output stability:** `acc_result` holds its value between completions.
- **Flag updates:** `acc_clear` effects appear after the edge that samples it; `acc_drop` sets on the edge that samples the offending `prod_valid`.

## Test plan
- **Basic chain:**
  - After reset, `prod`=0x3FF00000 (1.875) gives `acc_result`=0x3FF00000, `acc_count`=1, `acc_done` pulse 3 cycles after accept.
  - Then `prod`=0x40C00000 (6.0) gives 0x40FC0000 (7.875), `acc_count`=2.
- **Cancellation:** sum 0x40C00000 plus `prod`=0xC0C00000 gives 0x00000000. Then adding 0xC1400000 (-12.0) gives 0xC1400000.
- **Overflow:**
  - Sum 0x7F7FFFFF plus 0x7F7FFFFF gives 0x7F800000 and `acc_overflow`=1.
  - Separately, `prod_overflow`=1 with `prod`=0x3F800000 sets `acc_overflow` and leaves the sum unchanged.
- **Busy drop:** accept 0x3F800000 at E, pulse `prod_valid` at E+1. Result: `acc_drop`=1, `acc_result`=0x3F800000, `acc_count`=1.
- **Clear and abort:**
  - `acc_clear` at E+1 of an accept: no `acc_done`, all outputs 0, IDLE at E+2.
  - `acc_clear` together with `prod_valid` in IDLE: outputs 0 and `acc_drop`=0.
- **Reset and alignment:**
  - `rst` mid-NORM returns all outputs to 0.
  - Sum 0x4B800000 (2^24) plus 0x3F800000 (1.0) gives 0x4B800000; 1.0 is truncated away at an exponent difference of 24.

Source files
------------

// File: rtl/fp_accumulator_if.sv
// Product/result bundle between the multiplier side and the floating-point accumulator.
interface fp_accumulator_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               acc_clear;
  logic               prod_valid;
  logic               prod_overflow;
  logic [31:0]        prod;
  logic               acc_busy;
  logic               acc_done;
  logic [31:0]        acc_result;
  logic [COUNT_W-1:0] acc_count;
  logic               acc_overflow;
  logic               acc_drop;

  modport master (
    output acc_clear, prod_valid, prod_overflow, prod,
    input  acc_busy, acc_done, acc_result, acc_count, acc_overflow, acc_drop
  );

  modport slave (
    input  acc_clear, prod_valid, prod_overflow, prod,
    output acc_busy, acc_done, acc_result, acc_count, acc_overflow, acc_drop
  );
endinterface

// File: rtl/fp_accumulator.sv
// Single-precision running-sum accumulator: align, add and normalize over a fixed 3-cycle pipeline.
// Denormals flush to +0, alignment and normalization truncate, overflow saturates to infinity.
module fp_accumulator #(
  parameter int unsigned COUNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  fp_accumulator_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAlign, StAdd, StNorm} state_e;

  state_e state_q, state_d;

  logic [31:0]        result_q;
  logic [COUNT_W-1:0] count_q;
  logic               ovf_q, drop_q, done_q;
  logic [31:0]        prod_q;
  logic               special_q;

  // Align stage registers
  logic        al_sign_q, al_sub_q;
  logic [7:0]  al_exp_q;
  logic [23:0] al_big_q, al_small_q;

  // Add stage registers
  logic        ad_sign_q;
  logic [7:0]  ad_exp_q;
  logic [24:0] ad_sum_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.acc_clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.prod_valid) state_d = StAlign;
        StAlign: state_d = StAdd;
        StAdd:   state_d = StNorm;
        StNorm:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Operand decode; exponent 0 means +0 for either operand.
  logic        a_zero, b_zero, a_sign, b_sign, a_big;
  logic [7:0]  a_exp, b_exp, big_exp, small_exp, exp_diff;
  logic [23:0] a_man, b_man, big_man, small_man, small_sh;
  logic [30:0] a_mag, b_mag;

  assign a_exp  = result_q[30:23];
  assign b_exp  = prod_q[30:23];
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_sign = a_zero ? 1'b0 : result_q[31];
  assign b_sign = b_zero ? 1'b0 : prod_q[31];
  assign a_man  = a_zero ? 24'd0 : {1'b1, result_q[22:0]};
  assign b_man  = b_zero ? 24'd0 : {1'b1, prod_q[22:0]};
  assign a_mag  = a_zero ? 31'd0 : result_q[30:0];
  assign b_mag  = b_zero ? 31'd0 : prod_q[30:0];
  assign a_big  = (a_mag >= b_mag);

  assign big_exp   = a_big ? a_exp : b_exp;
  assign small_exp = a_big ? b_exp : a_exp;
  assign big_man   = a_big ? a_man : b_man;
  assign small_man = a_big ? b_man : a_man;
  assign exp_diff  = big_exp - small_exp;
  assign small_sh  = (exp_diff >= 8'd25) ? 24'd0 : (small_man >> exp_diff);

  logic [24:0] add_sum;
  assign add_sum = al_sub_q ? ({1'b0, al_big_q} - {1'b0, al_small_q})
                            : ({1'b0, al_big_q} + {1'b0, al_small_q});

  // Leading-zero count over the 24-bit mantissa field; highest set bit wins.
  logic [4:0] lzc;
  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (ad_sum_q[i]) lzc = 5'(23 - i);
    end
  end

  logic        carry;
  logic [9:0]  exp_adj;
  logic [22:0] frac_n;
  logic [31:0] norm_result;
  logic        norm_ovf;

  assign carry   = ad_sum_q[24];
  assign exp_adj = carry ? ({2'b00, ad_exp_q} + 10'd1) : ({2'b00, ad_exp_q} - {5'd0, lzc});
  assign frac_n  = carry ? ad_sum_q[23:1] : (ad_sum_q[22:0] << lzc);

  always_comb begin
    norm_result = 32'd0;
    norm_ovf    = 1'b0;
    if (ad_sum_q == 25'd0 || exp_adj[9] || exp_adj == 10'd0) begin
      norm_result = 32'd0;
    end else if (exp_adj >= 10'd255) begin
      norm_result = {ad_sign_q, 8'hFF, 23'd0};
      norm_ovf    = 1'b1;
    end else begin
      norm_result = {ad_sign_q, exp_adj[7:0], frac_n};
    end
  end

  // Pipeline datapath is only meaningful while its stage is active, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.prod_valid) begin
      prod_q    <= bus.prod;
      special_q <= bus.prod_overflow || (&bus.prod[30:23]);
    end
    if (state_q == StAlign) begin
      al_sign_q  <= a_big ? a_sign : b_sign;
      al_sub_q   <= a_sign ^ b_sign;
      al_exp_q   <= big_exp;
      al_big_q   <= big_man;
      al_small_q <= small_sh;
    end
    if (state_q == StAdd) begin
      ad_sum_q  <= add_sum;
      ad_exp_q  <= al_exp_q;
      ad_sign_q <= (add_sum == 25'd0) ? 1'b0 : al_sign_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.acc_clear) begin
      result_q <= 32'd0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && bus.prod_valid) drop_q <= 1'b1;
      if (state_q == StNorm) begin
        done_q <= 1'b1;
        if (count_q != '1) count_q <= count_q + 1'b1;
        if (special_q) begin
          ovf_q <= 1'b1;
        end else begin
          result_q <= norm_result;
          if (norm_ovf) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign bus.acc_busy     = (state_q != StIdle);
  assign bus.acc_done     = done_q;
  assign bus.acc_result   = result_q;
  assign bus.acc_count    = count_q;
  assign bus.acc_overflow = ovf_q;
  assign bus.acc_drop     = drop_q;

endmodule
